// File: rtl/fm_pkg.sv
// Shared definitions for the frequency meter peripheral: register map,
// FSM encoding and STATUS/CTRL bit positions.
package fm_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_PER_HI = 4'h2;
    localparam logic [3:0] ADDR_PER_LO = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h6;
    localparam logic [3:0] ADDR_STATE  = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } fm_state_e;

    localparam int unsigned CTRL_ENABLE  = 0;
    localparam int unsigned CTRL_CLR     = 1;

    localparam int unsigned STAT_VALID   = 0;
    localparam int unsigned STAT_TIMEOUT = 1;
    localparam int unsigned STAT_OVERRUN = 2;

endpackage

// File: rtl/freq_meter_core.sv
// Period measurement core: input synchronizer, rising-edge detector,
// ARM/MEASURE FSM with timeout, and the period/valid/timeout/overrun flags.
module freq_meter_core
    import fm_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] TIMEOUT     = 32'd50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clr_flags_i,
    input  logic             rd_lo_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             overrun_o,
    output fm_state_e        state_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    fm_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             at_limit;
    logic             capture;
    logic             tmo_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign at_limit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_ARM;
                ST_ARM:     if (rise) state_d = ST_MEASURE;
                ST_MEASURE: if (!rise && at_limit) state_d = ST_ARM;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // A rise restarts the count at 1 so the captured value equals the
    // cycle distance between consecutive rises; rise beats timeout.
    always_comb begin
        cnt_d   = '0;
        capture = 1'b0;
        tmo_evt = 1'b0;
        if (enable_i) begin
            case (state_q)
                ST_ARM, ST_MEASURE: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        capture = (state_q == ST_MEASURE);
                    end else if (at_limit) begin
                        tmo_evt = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_d = '0;
            endcase
        end

        period_d  = capture ? cnt_q : period_q;
        valid_d   = capture ? 1'b1 : ((rd_lo_i || clr_flags_i) ? 1'b0 : valid_q);
        timeout_d = tmo_evt ? 1'b1 : (clr_flags_i ? 1'b0 : timeout_q);
        overrun_d = clr_flags_i ? 1'b0
                  : (overrun_q | (capture & valid_q & ~rd_lo_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign period_o  = period_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule

// File: rtl/peripheral_freq_meter.sv
// J1 I/O-mapped frequency meter: bus decode, CTRL register, PER_LO shadow
// and registered read-data mux around freq_meter_core.
module peripheral_freq_meter
    import fm_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] TIMEOUT     = 32'd50_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        sig_in
);

    logic             wr_ctrl;
    logic             rd_stb;
    logic             rd_lo;
    logic             clr_flags;
    logic             enable_q, enable_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      d_out_q, d_out_d;
    logic [15:0]      rdata;
    logic [CNT_W-1:0] period;
    logic [31:0]      period32;
    logic             valid, timeout, overrun;
    fm_state_e        fsm_state;
    logic             unused_d_in;

    assign wr_ctrl     = cs && wr && (addr == ADDR_CTRL);
    assign rd_stb      = cs && rd;
    assign rd_lo       = rd_stb && (addr == ADDR_PER_LO);
    assign clr_flags   = wr_ctrl && d_in[CTRL_CLR];
    assign period32    = 32'(period);
    assign unused_d_in = ^d_in[15:2];

    freq_meter_core #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_q),
        .clr_flags_i (clr_flags),
        .rd_lo_i     (rd_lo),
        .sig_i       (sig_in),
        .period_o    (period),
        .valid_o     (valid),
        .timeout_o   (timeout),
        .overrun_o   (overrun),
        .state_o     (fsm_state)
    );

    // PER_HI and the shadow both sample the pre-edge period, so a capture
    // on the same edge cannot split the 32-bit pair.
    always_comb begin
        enable_d = wr_ctrl ? d_in[CTRL_ENABLE] : enable_q;
        shadow_d = shadow_q;
        rdata    = '0;
        case (addr)
            ADDR_PER_HI: rdata = period32[31:16];
            ADDR_PER_LO: rdata = shadow_q;
            ADDR_STATUS: begin
                rdata[STAT_VALID]   = valid;
                rdata[STAT_TIMEOUT] = timeout;
                rdata[STAT_OVERRUN] = overrun;
            end
            ADDR_STATE:  rdata = {14'b0, fsm_state};
            default:     rdata = '0;
        endcase
        if (rd_stb && (addr == ADDR_PER_HI)) shadow_d = period32[15:0];
        d_out_d = rd_stb ? rdata : d_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= 1'b0;
            shadow_q <= '0;
            d_out_q  <= '0;
        end else begin
            enable_q <= enable_d;
            shadow_q <= shadow_d;
            d_out_q  <= d_out_d;
        end
    end

    assign d_out = d_out_q;

endmodule
